// File: rtl/iir_pkg.sv
// Shared constants and helpers for the IIR filter output path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package iir_pkg;

  // Default sample width; matches the filter output y.
  localparam int DEF_DATA_W = 16;

  // Signed extremes of a default-width sample.
  localparam logic signed [15:0] DATA_MAX = 16'sh7FFF;
  localparam logic signed [15:0] DATA_MIN = 16'sh8000;

  // Accumulator width: one extra bit per doubling of the decimation ratio,
  // so the sum of R full-scale samples never wraps.
  function automatic int acc_width(input int data_w, input int dec_log2);
    return data_w + dec_log2;
  endfunction

endpackage

// File: rtl/dec_fifo.sv
// Synchronous FIFO holding decimated results until the consumer takes them.
// Latency: a pushed word is visible on pop_data the cycle after the push.
// Backpressure: push on full is accepted only if a pop happens the same cycle.
//
// Ports: clk, reset (async active-low), push/push_data, pop/pop_data (head),
//        full, empty, level (occupancy 0..2**AW).
module dec_fifo #(
  parameter int W  = 16,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (level == '0);
  assign do_pop   = pop & ~empty;
  // When full, a same-cycle pop frees the slot being written: the write
  // lands on the head entry that is leaving on this very edge.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/iir_decimator.sv
// Boxcar-average decimator (ratio 2**DEC_LOG2, half-up rounding) behind a small FIFO.
// Latency: result visible on out_data one cycle after the edge accepting the R-th sample.
// Backpressure: out_valid/out_ready; results arriving on a full FIFO are dropped and counted.
//
// Ports: clk, reset (async active-low), in_valid/in_data (signed filter samples),
//        out_valid/out_ready/out_data (FIFO head), fifo_level, overflow (sticky),
//        drop_count (saturating at 255), ovf_clr (sync clear of overflow bookkeeping).
module iir_decimator
  import iir_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEC_LOG2 = 2,
  parameter int FIFO_AW  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [FIFO_AW:0]  fifo_level,
  output logic              overflow,
  output logic [7:0]        drop_count,
  input  logic              ovf_clr
);

  localparam int ACC_W = acc_width(DATA_W, DEC_LOG2);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] in_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] rnd;
  logic [DEC_LOG2-1:0]     phase;
  logic [DATA_W-1:0]       result;
  logic [DEC_LOG2-1:0]     unused_frac;
  logic                    frame_done;
  logic                    pop;
  logic                    full;
  logic                    empty;
  logic                    drop;

  assign in_ext = {{DEC_LOG2{in_data[DATA_W-1]}}, in_data};
  assign sum    = acc + in_ext;
  assign rnd    = sum + ACC_W'(1 << (DEC_LOG2 - 1));
  // Taking the upper DATA_W bits is the arithmetic shift (floor). The sum of
  // R in-range samples plus R/2 always lands back inside DATA_W after the
  // shift, so no saturation is needed.
  assign result      = rnd[ACC_W-1:DEC_LOG2];
  assign unused_frac = rnd[DEC_LOG2-1:0];

  // Phase counts 0..R-1 and R is a power of two, so the last sample is all-ones.
  assign frame_done = in_valid & (&phase);
  assign out_valid  = ~empty;
  assign pop        = out_valid & out_ready;
  assign drop       = frame_done & full & ~pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc   <= '0;
      phase <= '0;
    end else if (in_valid) begin
      if (&phase) begin
        acc   <= '0;
        phase <= '0;
      end else begin
        acc   <= sum;
        phase <= phase + 1'b1;
      end
    end
  end

  // A drop in the same cycle as a clear still registers: the clear applies
  // to history, the new drop is counted afresh.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (ovf_clr)                  drop_count <= 8'd1;
      else if (drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
    end else if (ovf_clr) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

  dec_fifo #(
    .W  (DATA_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (frame_done),
    .push_data (result),
    .pop       (pop),
    .pop_data  (out_data),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

endmodule

// File: tb/tb_iir_decimator.sv
// Directed bench for iir_decimator with DEC_LOG2=2, FIFO_AW=2.
module tb_iir_decimator;
  import iir_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        ovf_clr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  iir_decimator #(.DATA_W(16), .DEC_LOG2(2), .FIFO_AW(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .drop_count (drop_count),
    .ovf_clr    (ovf_clr)
  );

  typedef struct {
    logic        vld;
    logic [15:0] d;
    logic        ev;
    logic [15:0] ed;
    logic [2:0]  el;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic vld, input logic [15:0] d, input logic ev,
                     input logic [15:0] ed, input logic [2:0] el);
    vec_t v;
    v.vld = vld; v.d = d; v.ev = ev; v.ed = ed; v.el = el;
    tbl.push_back(v);
  endtask

  // One clock: drive after the falling edge, return 1ns after the rising edge.
  task automatic cyc(input logic vld, input logic [15:0] d, input logic rdy, input logic clr);
    @(negedge clk);
    in_valid = vld; in_data = d; out_ready = rdy; ovf_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [15:0] v, input logic rdy);
    for (int i = 0; i < 4; i++) cyc(1'b1, v, rdy, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ovf",   32'(overflow),  32'd0);
    chk("rst_cnt",   32'(drop_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [15:0] exp_q[$];
    logic [15:0] prev;
    logic        rdy;

    // Average of 1..4, then rounding extremes and half-up ties.
    add(1, 16'd1, 0, 16'd0, 0); add(1, 16'd2, 0, 16'd0, 0);
    add(1, 16'd3, 0, 16'd0, 0); add(1, 16'd4, 1, 16'd3, 1);
    add(0, 16'd0, 0, 16'd0, 0);
    add(1, 16'hFFFF, 0, 16'd0, 0); add(1, 16'hFFFF, 0, 16'd0, 0);
    add(1, 16'hFFFF, 0, 16'd0, 0); add(1, 16'hFFFE, 1, 16'hFFFF, 1);
    add(1, DATA_MAX, 0, 16'd0, 0); add(1, DATA_MAX, 0, 16'd0, 0);
    add(1, DATA_MAX, 0, 16'd0, 0); add(1, DATA_MAX, 1, DATA_MAX, 1);
    add(1, DATA_MIN, 0, 16'd0, 0); add(1, DATA_MIN, 0, 16'd0, 0);
    add(1, DATA_MIN, 0, 16'd0, 0); add(1, DATA_MIN, 1, DATA_MIN, 1);
    add(1, 16'd1, 0, 16'd0, 0); add(1, 16'd1, 0, 16'd0, 0);
    add(1, 16'd1, 0, 16'd0, 0); add(1, 16'd0, 1, 16'd1, 1);
    add(1, 16'hFFFE, 0, 16'd0, 0); add(1, 16'd0, 0, 16'd0, 0);
    add(1, 16'd0, 0, 16'd0, 0); add(1, 16'd0, 1, 16'd0, 1);
    add(1, 16'd2, 0, 16'd0, 0); add(1, 16'd0, 0, 16'd0, 0);
    add(1, 16'd0, 0, 16'd0, 0); add(1, 16'd0, 1, 16'd1, 1);
    add(0, 16'd0, 0, 16'd0, 0);

    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].vld, tbl[i].d, 1'b1, 1'b0);
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(tbl[i].ed));
      chk($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(tbl[i].el));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'd0);
    end

    // Overrun: 5 results into a 4-deep FIFO with no consumer.
    for (int i = 0; i < 20; i++) cyc(1'b1, 16'd5, 1'b0, 1'b0);
    chk("ovr_level", 32'(fifo_level), 32'd4);
    chk("ovr_ovf",   32'(overflow),   32'd1);
    chk("ovr_cnt",   32'(drop_count), 32'd1);
    chk("ovr_head",  32'(out_data),   32'd5);
    frame(16'd5, 1'b0);
    chk("ovr_cnt2",  32'(drop_count), 32'd2);
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'd5, 1'b0, 1'b0);
    cyc(1'b1, 16'd5, 1'b0, 1'b1);
    chk("clr_drop_ovf", 32'(overflow),   32'd1);
    chk("clr_drop_cnt", 32'(drop_count), 32'd1);
    cyc(1'b0, 16'd0, 1'b0, 1'b1);
    chk("clr_ovf", 32'(overflow),   32'd0);
    chk("clr_cnt", 32'(drop_count), 32'd0);
    for (int i = 0; i < 260; i++) frame(16'd5, 1'b0);
    chk("sat_cnt",   32'(drop_count), 32'd255);
    chk("sat_level", 32'(fifo_level), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovr_drain%0d", i), 32'(out_data), 32'd5);
      cyc(1'b0, 16'd0, 1'b1, 1'b0);
    end
    chk("ovr_empty", 32'(out_valid), 32'd0);

    // Push and pop on the same edge while full.
    do_reset();
    frame(16'd10, 1'b0); frame(16'd20, 1'b0);
    frame(16'd30, 1'b0); frame(16'd40, 1'b0);
    chk("full_level", 32'(fifo_level), 32'd4);
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'd50, 1'b0, 1'b0);
    cyc(1'b1, 16'd50, 1'b1, 1'b0);
    chk("pp_level", 32'(fifo_level), 32'd4);
    chk("pp_ovf",   32'(overflow),   32'd0);
    chk("pp_cnt",   32'(drop_count), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pp_valid%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("pp_order%0d", i), 32'(out_data), 32'((i + 2) * 10));
      cyc(1'b0, 16'd0, 1'b1, 1'b0);
    end
    chk("pp_empty", 32'(out_valid), 32'd0);

    // Reset discards a partial frame.
    cyc(1'b1, 16'd100, 1'b1, 1'b0);
    cyc(1'b1, 16'd100, 1'b1, 1'b0);
    do_reset();
    frame(16'd8, 1'b1);
    chk("rstf_valid", 32'(out_valid), 32'd1);
    chk("rstf_data",  32'(out_data),  32'd8);
    cyc(1'b0, 16'd0, 1'b1, 1'b0);
    chk("rstf_single", 32'(out_valid), 32'd0);

    // Gaps in in_valid: held cycles carry junk data that must be ignored.
    cyc(1'b1, 16'd1, 1'b1, 1'b0);  cyc(1'b0, 16'd99, 1'b1, 1'b0);
    cyc(1'b1, 16'd2, 1'b1, 1'b0);  cyc(1'b0, 16'd99, 1'b1, 1'b0);
    cyc(1'b1, 16'd3, 1'b1, 1'b0);  cyc(1'b0, 16'd99, 1'b1, 1'b0);
    cyc(1'b1, 16'd4, 1'b1, 1'b0);
    chk("gap_valid", 32'(out_valid), 32'd1);
    chk("gap_data",  32'(out_data),  32'd3);
    cyc(1'b0, 16'd99, 1'b1, 1'b0);
    chk("gap_done", 32'(out_valid), 32'd0);

    // Random consumer stalls: head must stay put until accepted.
    frame(16'd11, 1'b0); frame(16'd22, 1'b0); frame(16'd33, 1'b0);
    exp_q.push_back(16'd11); exp_q.push_back(16'd22); exp_q.push_back(16'd33);
    for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      chk("rnd_valid", 32'(out_valid), 32'd1);
      chk("rnd_head",  32'(out_data),  32'(exp_q[0]));
      prev = out_data;
      rdy = 1'($urandom_range(0, 1));
      in_valid = 1'b0; out_ready = rdy;
      @(posedge clk);
      #1;
      if (rdy) void'(exp_q.pop_front());
      else     chk("rnd_stable", 32'(out_data), 32'(prev));
    end
    chk("rnd_drained", 32'(exp_q.size()), 32'd0);
    chk("rnd_empty",   32'(out_valid),    32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
